// File: rtl/neighbour_counter_if.sv
// Command/write bundle between the mine-placement side and neighbour_counter.
// NEIGHBOUR_STATS_EN adds the mine-count statistics signals.
interface neighbour_counter_if;
  logic         start;
  logic [4:0]   dimension_size;
  logic [255:0] mine_map;
  logic         wr_ready;
  logic         wr_en;
  logic [7:0]   wr_addr;
  logic [3:0]   wr_data;
  logic         busy;
  logic         done;
  logic         dim_err;
`ifdef NEIGHBOUR_STATS_EN
  logic [5:0]   mines;
  logic [8:0]   mine_total;
  logic         count_err;

  modport master (
    output start, dimension_size, mine_map, wr_ready, mines,
    input  wr_en, wr_addr, wr_data, busy, done, dim_err, mine_total, count_err
  );
  modport slave (
    input  start, dimension_size, mine_map, wr_ready, mines,
    output wr_en, wr_addr, wr_data, busy, done, dim_err, mine_total, count_err
  );
`else
  modport master (
    output start, dimension_size, mine_map, wr_ready,
    input  wr_en, wr_addr, wr_data, busy, done, dim_err
  );
  modport slave (
    input  start, dimension_size, mine_map, wr_ready,
    output wr_en, wr_addr, wr_data, busy, done, dim_err
  );
`endif
endinterface

// File: rtl/neighbour_counter.sv
// Snapshots a mine map and streams every active cell's neighbour count (or MINE_CODE)
// out through a valid/ready write port. Optional statistics: NEIGHBOUR_STATS_EN.
module neighbour_counter #(
  parameter int         MAX_DIM   = 16,
  parameter logic [3:0] MINE_CODE = 4'd9
) (
  input  logic                clk,
  input  logic                rst,
  neighbour_counter_if.slave  bus,
  output logic [1:0]          o_state
);
  // Write handshake: wr_en is valid; a write completes on a cycle where wr_en && wr_ready.
  // While wr_en is high and wr_ready is low, wr_addr/wr_data are held unchanged.
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_SCAN = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t       r_state;
  logic [255:0] r_snap;
  logic [4:0]   r_dim;
  logic [3:0]   r_x;
  logic [3:0]   r_y;
  logic         r_busy;
  logic         r_done;
  logic         r_dim_err;

  logic         w_dim_ok;
  logic         w_fire;
  logic         w_last_x;
  logic         w_last_y;
  logic         w_is_mine;
  logic [3:0]   w_count;
  logic [3:0]   w_data;
  logic signed [5:0] w_nx;
  logic signed [5:0] w_ny;

  assign w_dim_ok  = (bus.dimension_size != 5'd0) && (bus.dimension_size <= 5'(MAX_DIM));
  assign w_fire    = r_busy & bus.wr_ready;
  assign w_last_x  = ({1'b0, r_x} == r_dim - 5'd1);
  assign w_last_y  = ({1'b0, r_y} == r_dim - 5'd1);
  assign w_is_mine = r_snap[{r_y, r_x}];

  // Neighbours are counted only when they fall inside the active dim x dim board.
  always_comb begin
    w_count = '0;
    w_nx    = '0;
    w_ny    = '0;
    for (int dy = -1; dy <= 1; dy++) begin
      for (int dx = -1; dx <= 1; dx++) begin
        w_nx = 6'(int'(r_x) + dx);
        w_ny = 6'(int'(r_y) + dy);
        if (!(dx == 0 && dy == 0) &&
            (w_nx >= 6'sd0) && (w_nx < $signed({1'b0, r_dim})) &&
            (w_ny >= 6'sd0) && (w_ny < $signed({1'b0, r_dim})))
          w_count = w_count + {3'b000, r_snap[{w_ny[3:0], w_nx[3:0]}]};
      end
    end
  end

  assign w_data = w_is_mine ? MINE_CODE : w_count;

`ifdef NEIGHBOUR_STATS_EN
  logic [8:0] r_mine_total;
  logic       r_count_err;
  logic [8:0] w_total_next;

  assign w_total_next   = r_mine_total + {8'b0, w_is_mine};
  assign bus.mine_total = r_mine_total;
  assign bus.count_err  = r_count_err;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state   <= S_IDLE;
      r_snap    <= '0;
      r_dim     <= '0;
      r_x       <= '0;
      r_y       <= '0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_dim_err <= 1'b0;
`ifdef NEIGHBOUR_STATS_EN
      r_mine_total <= '0;
      r_count_err  <= 1'b0;
`endif
    end else begin
      case (r_state)
        S_IDLE: begin
          if (bus.start) begin
            r_snap    <= bus.mine_map;
            r_dim     <= bus.dimension_size;
            r_x       <= '0;
            r_y       <= '0;
            r_dim_err <= ~w_dim_ok;
`ifdef NEIGHBOUR_STATS_EN
            r_mine_total <= '0;
            r_count_err  <= 1'b0;
`endif
            if (w_dim_ok) begin
              r_state <= S_SCAN;
              r_busy  <= 1'b1;
            end else begin
              r_state <= S_DONE;
            end
          end
        end
        S_SCAN: begin
          if (w_fire) begin
`ifdef NEIGHBOUR_STATS_EN
            r_mine_total <= w_total_next;
`endif
            if (w_last_x) begin
              r_x <= '0;
              if (w_last_y) begin
                r_y     <= '0;
                r_busy  <= 1'b0;
                r_done  <= 1'b1;
                r_state <= S_DONE;
`ifdef NEIGHBOUR_STATS_EN
                r_count_err <= (w_total_next != {3'b000, bus.mines});
`endif
              end else begin
                r_y <= r_y + 4'd1;
              end
            end else begin
              r_x <= r_x + 4'd1;
            end
          end
        end
        S_DONE: begin
          // A rejected scan arrives here with done low and raises it one cycle later.
          if (r_done) begin
            r_done  <= 1'b0;
            r_state <= S_IDLE;
          end else begin
            r_done <= 1'b1;
`ifdef NEIGHBOUR_STATS_EN
            r_count_err <= (r_mine_total != {3'b000, bus.mines});
`endif
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.wr_en   = r_busy;
  assign bus.busy    = r_busy;
  assign bus.wr_addr = r_busy ? {r_y, r_x} : 8'h00;
  assign bus.wr_data = r_busy ? w_data : 4'h0;
  assign bus.done    = r_done;
  assign bus.dim_err = r_dim_err;
  assign o_state     = r_state;

endmodule
